// File: rtl/in_service_control.sv
// 8259A interrupt-acknowledge sequencer and In-Service Register.
// Optional automatic EOI is compiled in with `define IN_SERVICE_AEOI_EN.
module in_service_control #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interruptVector,
  input  logic       intaPulse,
  input  logic [4:0] vectorBase,
  input  logic       aeoiMode,
  input  logic       eoiCmd,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  output logic       cpu_int,
  output logic [7:0] ISR,
  output logic [7:0] irrClear,
  output logic [7:0] dataOut,
  output logic       dataOutValid,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ACK1 = 2'd2;

  logic [1:0] state, next_state;
  logic [2:0] level_q;
  logic       spurious_q;
  logic       accept, deliver;
  logic [7:0] set_mask, clr_mask, isr_next;

  // Lowest index wins, matching the fixed IR0-highest priority.
  function automatic logic [2:0] encode(input logic [7:0] v);
    encode = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) encode = i[2:0];
  endfunction

  assign accept    = (state == REQ) && intaPulse;
  assign deliver   = (state == ACK1) && intaPulse;
  assign fsm_state = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|interruptVector) next_state = REQ;
      REQ:     if (intaPulse) next_state = ACK1;
      ACK1:    if (intaPulse) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A non-specific EOI picks from the current ISR, so a same-cycle set is never its target.
  always_comb begin
    set_mask = 8'd0;
    clr_mask = 8'd0;
    if (accept && (|interruptVector))
      set_mask = 8'd1 << encode(interruptVector);
    if (eoiCmd)
      clr_mask = eoiSpecific ? (8'd1 << eoiLevel) : (ISR & (~ISR + 8'd1));
`ifdef IN_SERVICE_AEOI_EN
    if (deliver && aeoiMode && !spurious_q)
      clr_mask = clr_mask | (8'd1 << level_q);
`endif
    isr_next = (ISR & ~clr_mask) | set_mask;
  end

`ifndef IN_SERVICE_AEOI_EN
  logic unused_aeoi;
  assign unused_aeoi = aeoiMode;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cpu_int      <= 1'b0;
      ISR          <= 8'd0;
      irrClear     <= 8'd0;
      dataOut      <= 8'd0;
      dataOutValid <= 1'b0;
      level_q      <= 3'd0;
      spurious_q   <= 1'b0;
    end else begin
      state        <= next_state;
      cpu_int      <= (next_state == REQ);
      ISR          <= isr_next;
      irrClear     <= set_mask;
      dataOutValid <= deliver;
      if (deliver)
        dataOut <= {vectorBase, level_q};
      if (accept) begin
        spurious_q <= ~(|interruptVector);
        level_q    <= (|interruptVector) ? encode(interruptVector) : SPURIOUS_LEVEL;
      end
    end
  end

endmodule
